// File: rtl/control_unit.sv
// Sequencing FSM for the 8-bit accumulator datapath: start/fetch/decode/execute.
// Optional single-step mode is enabled by defining CU_SINGLE_STEP_EN (adds the 'step' input).
module control_unit #(
    parameter logic [1:0] ASEL_ALU = 2'd0,
    parameter logic [1:0] ASEL_IN  = 2'd1,
    parameter logic [1:0] ASEL_RAM = 2'd2
) (
    input  logic       clk,
    input  logic       clear,
    input  logic [2:0] IR75,
    input  logic       Aeq0,
    input  logic       Apos,
    input  logic       enter,
`ifdef CU_SINGLE_STEP_EN
    input  logic       step,
`endif
    output logic       IRload,
    output logic       JMPmux,
    output logic       PCload,
    output logic       Meminst,
    output logic       MemWr,
    output logic [1:0] Asel,
    output logic       Aload,
    output logic       Sub,
    output logic       halt,
    output logic [3:0] state
);

    typedef enum logic [3:0] {
        S_START  = 4'b0000,
        S_FETCH  = 4'b0001,
        S_DECODE = 4'b0010,
        S_LOAD   = 4'b1000,
        S_STORE  = 4'b1001,
        S_ADD    = 4'b1010,
        S_SUB    = 4'b1011,
        S_INPUT  = 4'b1100,
        S_JZ     = 4'b1101,
        S_JPOS   = 4'b1110,
        S_HALT   = 4'b1111
    } state_t;

    state_t state_q, state_d;
    logic   enter_q, enter_d;
    logic   enter_rise;

`ifdef CU_SINGLE_STEP_EN
    logic   step_q, step_d;
    logic   step_rise;
    assign step_d    = step;
    assign step_rise = step & ~step_q;
`endif

    assign enter_d    = enter;
    assign enter_rise = enter & ~enter_q;
    assign state      = state_q;

    always_ff @(posedge clk) begin
        if (clear) begin
            state_q <= S_START;
            enter_q <= 1'b0;
`ifdef CU_SINGLE_STEP_EN
            step_q  <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            enter_q <= enter_d;
`ifdef CU_SINGLE_STEP_EN
            step_q  <= step_d;
`endif
        end
    end

    always_comb begin
        state_d = state_q;
        IRload  = 1'b0;
        JMPmux  = 1'b0;
        PCload  = 1'b0;
        Meminst = 1'b0;
        MemWr   = 1'b0;
        Asel    = ASEL_ALU;
        Aload   = 1'b0;
        Sub     = 1'b0;
        halt    = 1'b0;
        unique case (state_q)
            S_START: begin
`ifdef CU_SINGLE_STEP_EN
                state_d = step_rise ? S_FETCH : S_START;
`else
                state_d = S_FETCH;
`endif
            end
            S_FETCH: begin
                IRload  = 1'b1;
                PCload  = 1'b1;
                state_d = S_DECODE;
            end
            S_DECODE: begin
                Meminst = 1'b1;
                state_d = state_t'({1'b1, IR75});
            end
            S_LOAD: begin
                Asel    = ASEL_RAM;
                Aload   = 1'b1;
                state_d = S_START;
            end
            S_STORE: begin
                Meminst = 1'b1;
                MemWr   = 1'b1;
                state_d = S_START;
            end
            S_ADD: begin
                Aload   = 1'b1;
                state_d = S_START;
            end
            S_SUB: begin
                Aload   = 1'b1;
                Sub     = 1'b1;
                state_d = S_START;
            end
            // Only a fresh press seen here completes the input; a held key must be re-pressed.
            S_INPUT: begin
                Asel    = ASEL_IN;
                Aload   = enter_rise;
                state_d = enter_rise ? S_START : S_INPUT;
            end
            S_JZ: begin
                JMPmux  = 1'b1;
                PCload  = Aeq0;
                state_d = S_START;
            end
            S_JPOS: begin
                JMPmux  = 1'b1;
                PCload  = Apos;
                state_d = S_START;
            end
            S_HALT: begin
                halt    = 1'b1;
                state_d = S_HALT;
            end
            default: state_d = S_START;
        endcase
    end

endmodule

// File: tb/tb_control_unit.sv
// Directed self-checking bench for control_unit: reset, every opcode, INPUT handshake,
// HALT hold and clear priority, checked with immediate assertions.
module tb_control_unit;

    logic       clk;
    logic       clear;
    logic [2:0] IR75;
    logic       Aeq0;
    logic       Apos;
    logic       enter;
`ifdef CU_SINGLE_STEP_EN
    logic       step;
`endif
    logic       IRload, JMPmux, PCload, Meminst, MemWr, Aload, Sub, halt;
    logic [1:0] Asel;
    logic [3:0] state;
    logic [9:0] ctrl;

    int assertCount;
    int failCount;

    control_unit dut (
        .clk    (clk),
        .clear  (clear),
        .IR75   (IR75),
        .Aeq0   (Aeq0),
        .Apos   (Apos),
        .enter  (enter),
`ifdef CU_SINGLE_STEP_EN
        .step   (step),
`endif
        .IRload (IRload),
        .JMPmux (JMPmux),
        .PCload (PCload),
        .Meminst(Meminst),
        .MemWr  (MemWr),
        .Asel   (Asel),
        .Aload  (Aload),
        .Sub    (Sub),
        .halt   (halt),
        .state  (state)
    );

    // Packed view of the control lines: IRload,JMPmux,PCload,Meminst,MemWr,Asel[1:0],Aload,Sub,halt
    assign ctrl = {IRload, JMPmux, PCload, Meminst, MemWr, Asel, Aload, Sub, halt};

    localparam logic [9:0] C_NONE   = 10'b00000_00_000;
    localparam logic [9:0] C_FETCH  = 10'b10100_00_000;
    localparam logic [9:0] C_DECODE = 10'b00010_00_000;
    localparam logic [9:0] C_LOAD   = 10'b00000_10_100;
    localparam logic [9:0] C_STORE  = 10'b00011_00_000;
    localparam logic [9:0] C_ADD    = 10'b00000_00_100;
    localparam logic [9:0] C_SUB    = 10'b00000_00_110;
    localparam logic [9:0] C_INWAIT = 10'b00000_01_000;
    localparam logic [9:0] C_INDONE = 10'b00000_01_100;
    localparam logic [9:0] C_JTAKE  = 10'b01100_00_000;
    localparam logic [9:0] C_JSKIP  = 10'b01000_00_000;
    localparam logic [9:0] C_HALT   = 10'b00000_00_001;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one rising edge and settle so sampling is away from the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [3:0] expState, input logic [9:0] expCtrl);
        assertCount++;
        assert (state === expState)
        else begin
            failCount++;
            $error("[TB] FAIL %s state observed=%b expected=%b", tag, state, expState);
        end
        assertCount++;
        assert (ctrl === expCtrl)
        else begin
            failCount++;
            $error("[TB] FAIL %s ctrl observed=%b expected=%b", tag, ctrl, expCtrl);
        end
    endtask

    // From START: runs FETCH, DECODE, the execute cycle, then returns to START.
    task automatic applyStimulus(input string tag, input logic [2:0] op,
                                 input logic [3:0] execState, input logic [9:0] execCtrl);
        IR75 = op;
        tick();
        checkOutput({tag, "_fetch"}, 4'b0001, C_FETCH);
        tick();
        checkOutput({tag, "_decode"}, 4'b0010, C_DECODE);
        tick();
        checkOutput({tag, "_exec"}, execState, execCtrl);
        tick();
        checkOutput({tag, "_done"}, 4'b0000, C_NONE);
    endtask

    initial begin
        assertCount = 0;
        failCount   = 0;
        clear = 1'b1;
        IR75  = 3'b000;
        Aeq0  = 1'b0;
        Apos  = 1'b0;
        enter = 1'b0;
`ifdef CU_SINGLE_STEP_EN
        step  = 1'b0;
`endif
        tick();
        tick();
        clear = 1'b0;
        checkOutput("reset", 4'b0000, C_NONE);

        applyStimulus("load", 3'b000, 4'b1000, C_LOAD);
        applyStimulus("store", 3'b001, 4'b1001, C_STORE);
        applyStimulus("add", 3'b010, 4'b1010, C_ADD);
        applyStimulus("sub", 3'b011, 4'b1011, C_SUB);

        Aeq0 = 1'b1;
        applyStimulus("jz_taken", 3'b101, 4'b1101, C_JTAKE);
        Aeq0 = 1'b0;
        applyStimulus("jz_not", 3'b101, 4'b1101, C_JSKIP);
        Apos = 1'b1;
        applyStimulus("jpos_taken", 3'b110, 4'b1110, C_JTAKE);
        Apos = 1'b0;
        Aeq0 = 1'b1;
        applyStimulus("jpos_not", 3'b110, 4'b1110, C_JSKIP);
        Aeq0 = 1'b0;

        // INPUT with enter already held on entry: must wait for release and re-press.
        enter = 1'b1;
        IR75  = 3'b100;
        tick();
        checkOutput("in_fetch", 4'b0001, C_FETCH);
        tick();
        checkOutput("in_decode", 4'b0010, C_DECODE);
        tick();
        checkOutput("in_held", 4'b1100, C_INWAIT);
        tick();
        checkOutput("in_held2", 4'b1100, C_INWAIT);
        enter = 1'b0;
        tick();
        checkOutput("in_released", 4'b1100, C_INWAIT);
        enter = 1'b1;
        #1;
        checkOutput("in_press", 4'b1100, C_INDONE);
        tick();
        enter = 1'b0;
        checkOutput("in_done", 4'b0000, C_NONE);

        // clear during DECODE overrides the pending LOAD.
        IR75 = 3'b000;
        tick();
        tick();
        checkOutput("clr_dec_pre", 4'b0010, C_DECODE);
        clear = 1'b1;
        tick();
        clear = 1'b0;
        checkOutput("clr_decode", 4'b0000, C_NONE);

        // clear while waiting in INPUT.
        IR75 = 3'b100;
        tick();
        tick();
        tick();
        checkOutput("clr_in_pre", 4'b1100, C_INWAIT);
        clear = 1'b1;
        tick();
        clear = 1'b0;
        checkOutput("clr_input", 4'b0000, C_NONE);

        // HALT holds for 20 cycles, then clear releases it.
        IR75 = 3'b111;
        tick();
        tick();
        tick();
        checkOutput("halt_enter", 4'b1111, C_HALT);
        for (int i = 0; i < 20; i++) begin
            tick();
            checkOutput("halt_hold", 4'b1111, C_HALT);
        end
        clear = 1'b1;
        tick();
        clear = 1'b0;
        checkOutput("clr_halt", 4'b0000, C_NONE);
        tick();
        checkOutput("post_clr_fetch", 4'b0001, C_FETCH);

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
